sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_if.sv | 49 ++++
 rtl/sram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the datapath and Wishbone requesters, the arbiter, and a 1R1W SRAM.
// The slave modport is the arbiter's view; the master modport is the requesters'/SRAM's view.
interface sram_port_arbiter_if;
  logic        dp_rd_valid;
  logic        dp_rd_ready;
  logic [7:0]  dp_rd_addr;
  logic        dp_rdata_valid;
  logic [31:0] dp_rdata;
  logic        dp_wr_valid;
  logic        dp_wr_ready;
  logic [7:0]  dp_wr_addr;
  logic [31:0] dp_wr_data;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic [7:0]  R0_addr;
  logic        R0_en;
  logic        R0_clk;
  logic [31:0] R0_data;
  logic [7:0]  W0_addr;
  logic        W0_en;
  logic        W0_clk;
  logic [31:0] W0_data;

  modport slave (
    input  dp_rd_valid, dp_rd_addr, dp_wr_valid, dp_wr_addr, dp_wr_data,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  R0_data,
    output dp_rd_ready, dp_rdata_valid, dp_rdata, dp_wr_ready,
    output wbs_ack_o, wbs_dat_o,
    output R0_addr, R0_en, R0_clk, W0_addr, W0_en, W0_clk, W0_data
  );

  modport master (
    output dp_rd_valid, dp_rd_addr, dp_wr_valid, dp_wr_addr, dp_wr_data,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output R0_data,
    input  dp_rd_ready, dp_rdata_valid, dp_rdata, dp_wr_ready,
    input  wbs_ack_o, wbs_dat_o,
    input  R0_addr, R0_en, R0_clk, W0_addr, W0_en, W0_clk, W0_data
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares a 1R1W SRAM between a datapath port and a Wishbone classic slave (with byte-lane RMW).
// Build option SRAM_ARB_RR_EN: per-port round-robin on conflict; default is fixed datapath priority.
module sram_port_arbiter (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  sram_port_arbiter_if.slave bus
);
  // state      | meaning
  // IDLE       | waiting for cyc & stb
  // RD_ISSUE   | requesting the read port (plain read or RMW pre-read)
  // RD_CAPTURE | SRAM word returning; capture it, merge byte lanes for RMW
  // WR_ISSUE   | requesting the write port with full or merged word
  // ACK        | one-cycle wbs_ack_o pulse
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, ACK} state_t;

  state_t      state;
  logic        ack;
  logic        rdata_valid;
  logic [31:0] cap_word;
  logic [31:0] wr_word;
  logic [31:0] merged_word;
  logic [7:0]  op_addr;
  logic [3:0]  op_sel;
  logic [31:0] op_dat;
  logic        op_we;

  logic wb_rd_req;
  logic wb_wr_req;
  logic rmw_lock;
  logic dp_rd_avail;
  logic dp_wr_avail;
  logic dp_rd_gnt;
  logic dp_wr_gnt;
  logic wb_rd_gnt;
  logic wb_wr_gnt;
  logic unused_adr_bits;

  assign wb_rd_req = (state == RD_ISSUE);
  assign wb_wr_req = (state == WR_ISSUE);
  // Write port stays with WB from the pre-read until the merged word lands.
  assign rmw_lock  = op_we && (op_sel != 4'hF) &&
                     ((state == RD_ISSUE) || (state == RD_CAPTURE) || (state == WR_ISSUE));

`ifdef SRAM_ARB_RR_EN
  logic rd_prio_dp;
  logic wr_prio_dp;

  assign dp_rd_avail = !wb_rst_i && (!wb_rd_req || rd_prio_dp);
  assign dp_wr_avail = !wb_rst_i && !rmw_lock && (!wb_wr_req || wr_prio_dp);
  assign wb_rd_gnt   = !wb_rst_i && wb_rd_req && (!bus.dp_rd_valid || !rd_prio_dp);
  assign wb_wr_gnt   = !wb_rst_i && wb_wr_req &&
                       (rmw_lock || !bus.dp_wr_valid || !wr_prio_dp);

  // On a conflict the winner drops to lowest priority for the next conflict.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_prio_dp <= 1'b1;
      wr_prio_dp <= 1'b1;
    end else begin
      if (bus.dp_rd_valid && wb_rd_req)
        rd_prio_dp <= wb_rd_gnt;
      if (bus.dp_wr_valid && wb_wr_req && !rmw_lock)
        wr_prio_dp <= wb_wr_gnt;
    end
  end
`else
  assign dp_rd_avail = !wb_rst_i;
  assign dp_wr_avail = !wb_rst_i && !rmw_lock;
  assign wb_rd_gnt   = !wb_rst_i && wb_rd_req && !bus.dp_rd_valid;
  assign wb_wr_gnt   = !wb_rst_i && wb_wr_req && (rmw_lock || !bus.dp_wr_valid);
`endif

  assign dp_rd_gnt = bus.dp_rd_valid && dp_rd_avail;
  assign dp_wr_gnt = bus.dp_wr_valid && dp_wr_avail;

  always_comb begin
    merged_word = bus.R0_data;
    for (int b = 0; b < 4; b++)
      if (op_sel[b]) merged_word[8*b +: 8] = op_dat[8*b +: 8];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      ack         <= 1'b0;
      rdata_valid <= 1'b0;
      cap_word    <= 32'h0;
      wr_word     <= 32'h0;
      op_addr     <= 8'h0;
      op_sel      <= 4'h0;
      op_dat      <= 32'h0;
      op_we       <= 1'b0;
    end else begin
      rdata_valid <= dp_rd_gnt;
      ack         <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
            op_addr <= bus.wbs_adr_i[9:2];
            op_sel  <= bus.wbs_sel_i;
            op_dat  <= bus.wbs_dat_i;
            op_we   <= bus.wbs_we_i;
            wr_word <= bus.wbs_dat_i;
            state   <= (bus.wbs_we_i && (bus.wbs_sel_i == 4'hF)) ? WR_ISSUE : RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (wb_rd_gnt) state <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          cap_word <= bus.R0_data;
          if (op_we) begin
            wr_word <= merged_word;
            state   <= WR_ISSUE;
          end else begin
            ack   <= 1'b1;
            state <= ACK;
          end
        end
        WR_ISSUE: begin
          if (wb_wr_gnt) begin
            ack   <= 1'b1;
            state <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dp_rd_ready    = dp_rd_avail;
  assign bus.dp_wr_ready    = dp_wr_avail;
  assign bus.dp_rdata_valid = rdata_valid;
  assign bus.dp_rdata       = rdata_valid ? bus.R0_data : 32'h0;

  assign bus.wbs_ack_o = ack;
  assign bus.wbs_dat_o = ((state == ACK) && !op_we) ? cap_word : 32'h0;

  assign bus.R0_clk  = wb_clk_i;
  assign bus.W0_clk  = wb_clk_i;
  assign bus.R0_en   = dp_rd_gnt || wb_rd_gnt;
  assign bus.R0_addr = dp_rd_gnt ? bus.dp_rd_addr : (wb_rd_gnt ? op_addr : 8'h0);
  assign bus.W0_en   = dp_wr_gnt || wb_wr_gnt;
  assign bus.W0_addr = dp_wr_gnt ? bus.dp_wr_addr : (wb_wr_gnt ? op_addr : 8'h0);
  assign bus.W0_data = dp_wr_gnt ? bus.dp_wr_data : (wb_wr_gnt ? wr_word : 32'h0);

  assign unused_adr_bits = ^{bus.wbs_adr_i[31:10], bus.wbs_adr_i[1:0]};
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus pushes expected read returns, acks and SRAM
// writes; a negedge monitor pops and compares whenever the DUT presents them.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();

  sram_port_arbiter dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  // 1R1W SRAM model, one-cycle read latency, read-before-write on same address
  logic [31:0] mem [256];
  logic [31:0] sram_q;
  always @(posedge clk) begin
    if (bus.R0_en === 1'b1) sram_q <= mem[bus.R0_addr];
    if (bus.W0_en === 1'b1) mem[bus.W0_addr] <= bus.W0_data;
  end
  assign bus.R0_data = sram_q;

  logic [31:0] exp_rd_q  [$];
  logic [31:0] exp_ack_q [$];
  logic [39:0] exp_wr_q  [$];
  string       chk_name_q [$];
  logic [39:0] chk_act_q  [$];
  logic [39:0] chk_exp_q  [$];
  int n_checks = 0;
  int n_errors = 0;

  always @(negedge clk) begin
    string       nm;
    logic [39:0] a40;
    logic [39:0] e40;
    logic [31:0] e32;
    while (chk_name_q.size() > 0) begin
      nm  = chk_name_q.pop_front();
      a40 = chk_act_q.pop_front();
      e40 = chk_exp_q.pop_front();
      n_checks++;
      if (a40 !== e40) begin
        n_errors++;
        $display("FAIL %s: got %0h, expected %0h", nm, a40, e40);
      end
    end
    if (bus.dp_rdata_valid === 1'b1) begin
      n_checks++;
      if (exp_rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL dp_rdata: got unexpected %0h, expected no return", bus.dp_rdata);
      end else begin
        e32 = exp_rd_q.pop_front();
        if (bus.dp_rdata !== e32) begin
          n_errors++;
          $display("FAIL dp_rdata: got %0h, expected %0h", bus.dp_rdata, e32);
        end
      end
    end
    if (bus.wbs_ack_o === 1'b1) begin
      n_checks++;
      if (exp_ack_q.size() == 0) begin
        n_errors++;
        $display("FAIL wbs_ack: got unexpected ack dat %0h, expected no ack", bus.wbs_dat_o);
      end else begin
        e32 = exp_ack_q.pop_front();
        if (bus.wbs_dat_o !== e32) begin
          n_errors++;
          $display("FAIL wbs_dat_o: got %0h, expected %0h", bus.wbs_dat_o, e32);
        end
      end
    end
    if (bus.W0_en === 1'b1) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_errors++;
        $display("FAIL sram_write: got unexpected addr %0h data %0h, expected none",
                 bus.W0_addr, bus.W0_data);
      end else begin
        e40 = exp_wr_q.pop_front();
        if ({bus.W0_addr, bus.W0_data} !== e40) begin
          n_errors++;
          $display("FAIL sram_write: got %0h, expected %0h", {bus.W0_addr, bus.W0_data}, e40);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    chk_name_q.push_back(nm);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_drive(input logic we, input logic [3:0] sel, input logic [7:0] word,
                          input logic [31:0] dat);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = {22'd0, word, 2'b00};
    bus.wbs_dat_i = dat;
  endtask

  task automatic wb_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    @(negedge clk);
    while (bus.wbs_ack_o !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("wb_ack_timeout", 40'd0, 40'd1);
  endtask

  task automatic dp_write(input logic [7:0] a, input logic [31:0] d);
    int n;
    tick();
    bus.dp_wr_valid = 1'b1;
    bus.dp_wr_addr  = a;
    bus.dp_wr_data  = d;
    exp_wr_q.push_back({a, d});
    n = 0;
    @(negedge clk);
    while (bus.dp_wr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("dp_wr_timeout", 40'd0, 40'd1);
    tick();
    bus.dp_wr_valid = 1'b0;
    bus.dp_wr_addr  = 8'h0;
    bus.dp_wr_data  = 32'h0;
  endtask

  task automatic dp_read(input logic [7:0] a, input logic [31:0] exp);
    int n;
    tick();
    bus.dp_rd_valid = 1'b1;
    bus.dp_rd_addr  = a;
    exp_rd_q.push_back(exp);
    n = 0;
    @(negedge clk);
    while (bus.dp_rd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("dp_rd_timeout", 40'd0, 40'd1);
    tick();
    bus.dp_rd_valid = 1'b0;
    bus.dp_rd_addr  = 8'h0;
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [7:0] word,
                         input logic [31:0] dat, input logic [31:0] ack_dat, output int lat);
    tick();
    wb_drive(we, sel, word, dat);
    exp_ack_q.push_back(ack_dat);
    wait_ack(lat);
    tick();
    wb_idle();
  endtask

  initial begin
    int   lat;
    int   dp_ok;
    logic wb_seen;
    logic acked;

    rst = 1'b1;
    bus.dp_rd_valid = 1'b0;
    bus.dp_rd_addr  = 8'h0;
    bus.dp_wr_valid = 1'b0;
    bus.dp_wr_addr  = 8'h0;
    bus.dp_wr_data  = 32'h0;
    wb_idle();

    // Reset state with every requester active
    tick();
    tick();
    bus.dp_rd_valid = 1'b1;
    bus.dp_rd_addr  = 8'h05;
    bus.dp_wr_valid = 1'b1;
    bus.dp_wr_addr  = 8'h05;
    bus.dp_wr_data  = 32'h1234;
    wb_drive(1'b0, 4'hF, 8'h05, 32'h0);
    @(negedge clk);
    check("rst_readies", {bus.dp_rd_ready, bus.dp_wr_ready}, 40'd0);
    check("rst_sram_en", {bus.R0_en, bus.W0_en}, 40'd0);
    check("rst_wb_out", {bus.wbs_ack_o, bus.wbs_dat_o}, 40'd0);
    check("rst_rdata_valid", bus.dp_rdata_valid, 40'd0);
    tick();
    bus.dp_rd_valid = 1'b0;
    bus.dp_wr_valid = 1'b0;
    wb_idle();
    tick();
    rst = 1'b0;

    dp_write(8'd4,  32'hDEADBEEF);
    dp_write(8'd1,  32'h00000111);
    dp_write(8'd9,  32'h11223344);
    dp_write(8'd7,  32'hAAAA0007);
    dp_write(8'd12, 32'h0C0C0C0C);
    dp_write(8'd3,  32'h00000099);
    dp_read(8'd4, 32'hDEADBEEF);

    // WB read of word 4 with no dp traffic: R0 in cycle 1, ack in cycle 3
    tick();
    wb_drive(1'b0, 4'hF, 8'd4, 32'h0);
    exp_ack_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("wbrd_c0_r0_en", bus.R0_en, 40'd0);
    @(negedge clk);
    check("wbrd_c1_r0", {bus.R0_en, bus.R0_addr}, {31'd0, 1'b1, 8'h04});
    @(negedge clk);
    check("wbrd_c2_ack", bus.wbs_ack_o, 40'd0);
    @(negedge clk);
    check("wbrd_c3_ack", bus.wbs_ack_o, 40'd1);
    tick();
    wb_idle();
    @(negedge clk);
    check("wbrd_dat_after_ack", {bus.wbs_ack_o, bus.wbs_dat_o}, 40'd0);

    // Full-word WB write, then a partial-select read that drops cyc after one cycle
    exp_wr_q.push_back({8'd20, 32'hCAFEF00D});
    wb_xfer(1'b1, 4'hF, 8'd20, 32'hCAFEF00D, 32'h0, lat);
    check("wbwr_full_latency", lat, 40'd2);
    tick();
    wb_drive(1'b0, 4'h3, 8'd20, 32'h0);
    exp_ack_q.push_back(32'hCAFEF00D);
    tick();
    wb_idle();
    wait_ack(lat);
    check("wb_abandoned_cyc_latency", lat, 40'd2);
    repeat (3) tick();

    // Byte-lane RMW: sel 0010 into 0x11223344
    exp_wr_q.push_back({8'd9, 32'h1122AB44});
    wb_xfer(1'b1, 4'b0010, 8'd9, 32'h0000AB00, 32'h0, lat);
    check("rmw_latency", lat, 40'd4);
    dp_read(8'd9, 32'h1122AB44);

    // Same-cycle dp write and dp read of word 3
    tick();
    bus.dp_wr_valid = 1'b1;
    bus.dp_wr_addr  = 8'd3;
    bus.dp_wr_data  = 32'h00000055;
    bus.dp_rd_valid = 1'b1;
    bus.dp_rd_addr  = 8'd3;
    exp_wr_q.push_back({8'd3, 32'h00000055});
    exp_rd_q.push_back(32'h00000099);
    @(negedge clk);
    check("same_cycle_readies", {bus.dp_rd_ready, bus.dp_wr_ready}, 40'd3);
    tick();
    bus.dp_wr_valid = 1'b0;
    bus.dp_rd_valid = 1'b0;
    dp_read(8'd3, 32'h00000055);

    // dp write to word 7 during WB RMW of word 7
    tick();
    wb_drive(1'b1, 4'b0001, 8'd7, 32'h000000CC);
    exp_wr_q.push_back({8'd7, 32'hAAAA00CC});
    exp_wr_q.push_back({8'd7, 32'h77777777});
    exp_ack_q.push_back(32'h0);
    tick();
    bus.dp_wr_valid = 1'b1;
    bus.dp_wr_addr  = 8'd7;
    bus.dp_wr_data  = 32'h77777777;
    @(negedge clk);
    check("rmw_lock_rd_issue", bus.dp_wr_ready, 40'd0);
    @(negedge clk);
    check("rmw_lock_rd_capture", bus.dp_wr_ready, 40'd0);
    @(negedge clk);
    check("rmw_lock_wr_issue", bus.dp_wr_ready, 40'd0);
    @(negedge clk);
    check("rmw_release_at_ack", {bus.wbs_ack_o, bus.dp_wr_ready}, 40'd3);
    tick();
    bus.dp_wr_valid = 1'b0;
    wb_idle();
    dp_read(8'd7, 32'h77777777);

    // dp read held high while a WB read of word 4 is pending
    tick();
    wb_drive(1'b0, 4'hF, 8'd4, 32'h0);
    exp_ack_q.push_back(32'hDEADBEEF);
    bus.dp_rd_valid = 1'b1;
    bus.dp_rd_addr  = 8'd1;
    dp_ok   = 0;
    wb_seen = 1'b0;
    acked   = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.dp_rd_ready === 1'b1) begin
        dp_ok++;
        exp_rd_q.push_back(32'h00000111);
      end
      if (bus.R0_en === 1'b1 && bus.R0_addr == 8'd4 && !wb_seen) begin
        wb_seen = 1'b1;
        check("rr_wb_grant_within_2", (c <= 2) ? 40'd1 : 40'd0, 40'd1);
      end
      if (bus.wbs_ack_o === 1'b1) acked = 1'b1;
      tick();
      if (acked) wb_idle();
    end
`ifdef SRAM_ARB_RR_EN
    check("rr_wb_granted", wb_seen, 40'd1);
`else
    check("fixed_dp_always_ready", dp_ok, 40'd8);
    check("fixed_wb_starved", wb_seen, 40'd0);
`endif
    bus.dp_rd_valid = 1'b0;
    if (!acked) begin
      wait_ack(lat);
      tick();
      wb_idle();
    end
    repeat (2) tick();

    // Reset during RD_CAPTURE of a partial write: no write, no ack
    tick();
    wb_drive(1'b1, 4'b0100, 8'd12, 32'h00EE0000);
    @(negedge clk);
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_rmw_no_write", bus.W0_en, 40'd0);
    tick();
    wb_idle();
    @(negedge clk);
    check("rst_rmw_outputs",
          {bus.wbs_ack_o, bus.wbs_dat_o, bus.dp_rdata_valid, bus.R0_en, bus.W0_en}, 40'd0);
    tick();
    rst = 1'b0;
    dp_read(8'd12, 32'h0C0C0C0C);

    repeat (4) tick();
    check("exp_rd_left", exp_rd_q.size(), 40'd0);
    check("exp_ack_left", exp_ack_q.size(), 40'd0);
    check("exp_wr_left", exp_wr_q.size(), 40'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
